// File: rtl/instr_fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: PC register, instruction-memory handshake
// with a one-entry hold buffer for stalls, and the IF/ID pipeline register.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWrite,
    input  logic        IF_IDWrite,
    input  logic        PCSrc,
    input  logic [31:0] BranchTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] IF_ID_Instr,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic [4:0]  IF_ID_RegisterRs,
    output logic [4:0]  IF_ID_RegisterRt
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        BUF  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] hold_buf_q, hold_buf_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] if_id_pcplus4_q, if_id_pcplus4_d;
    logic        if_id_valid_q, if_id_valid_d;

    logic        advance;
    logic [31:0] pc_plus4;

    assign advance  = PCWrite & IF_IDWrite;
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        req_addr_d      = req_addr_q;
        hold_buf_d      = hold_buf_q;
        if_id_instr_d   = if_id_instr_q;
        if_id_pcplus4_d = if_id_pcplus4_q;
        if_id_valid_d   = if_id_valid_q;

        if (PCSrc) begin
            // A redirect always flushes IF/ID, even when decode asked to hold it.
            pc_d          = BranchTarget;
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
            case (state_q)
                REQ: begin
                    if (!imem_ready) begin
                        req_addr_d = pc_q;
                        state_d    = DROP;
                    end else begin
                        state_d = REQ;
                    end
                end
                BUF:     state_d = REQ;
                default: state_d = DROP;
            endcase
        end else if (state_q == DROP && imem_ready) begin
            state_d = REQ;
            if (IF_IDWrite) begin
                if_id_instr_d = NOP_INSTR;
                if_id_valid_d = 1'b0;
            end
        end else if (state_q == REQ && imem_ready) begin
            if (advance) begin
                if_id_instr_d   = imem_rdata;
                if_id_pcplus4_d = pc_plus4;
                if_id_valid_d   = 1'b1;
                pc_d            = pc_plus4;
            end else begin
                hold_buf_d = imem_rdata;
                state_d    = BUF;
            end
        end else if (state_q == BUF) begin
            if (advance) begin
                if_id_instr_d   = hold_buf_q;
                if_id_pcplus4_d = pc_plus4;
                if_id_valid_d   = 1'b1;
                pc_d            = pc_plus4;
                state_d         = REQ;
            end
        end else begin
            // Memory still busy: insert a latency bubble unless decode is holding.
            if (IF_IDWrite) begin
                if_id_instr_d = NOP_INSTR;
                if_id_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= REQ;
            pc_q            <= RESET_PC;
            req_addr_q      <= RESET_PC;
            hold_buf_q      <= 32'd0;
            if_id_instr_q   <= NOP_INSTR;
            if_id_pcplus4_q <= 32'd0;
            if_id_valid_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            req_addr_q      <= req_addr_d;
            hold_buf_q      <= hold_buf_d;
            if_id_instr_q   <= if_id_instr_d;
            if_id_pcplus4_q <= if_id_pcplus4_d;
            if_id_valid_q   <= if_id_valid_d;
        end
    end

    // DROP keeps presenting the abandoned address so the memory sees a stable request.
    assign imem_req  = !rst && (state_q != BUF);
    assign imem_addr = (state_q == DROP) ? req_addr_q : pc_q;

    assign PC               = pc_q;
    assign IF_ID_Instr      = if_id_instr_q;
    assign IF_ID_PCPlus4    = if_id_pcplus4_q;
    assign IF_ID_Valid      = if_id_valid_q;
    assign IF_ID_RegisterRs = if_id_instr_q[25:21];
    assign IF_ID_RegisterRt = if_id_instr_q[20:16];

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed self-checking bench for instr_fetch_stage; memory returns an
// address-derived word so every fetched instruction identifies its address.
module tb_instr_fetch_stage;

    logic        clk;
    logic        rst;
    logic        PCWrite;
    logic        IF_IDWrite;
    logic        PCSrc;
    logic [31:0] BranchTarget;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] PC;
    logic [31:0] IF_ID_Instr;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;
    logic [4:0]  IF_ID_RegisterRs;
    logic [4:0]  IF_ID_RegisterRt;

    int checkCount = 0;
    int errorCount = 0;

    instr_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .PCWrite         (PCWrite),
        .IF_IDWrite      (IF_IDWrite),
        .PCSrc           (PCSrc),
        .BranchTarget    (BranchTarget),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .PC              (PC),
        .IF_ID_Instr     (IF_ID_Instr),
        .IF_ID_PCPlus4   (IF_ID_PCPlus4),
        .IF_ID_Valid     (IF_ID_Valid),
        .IF_ID_RegisterRs(IF_ID_RegisterRs),
        .IF_ID_RegisterRt(IF_ID_RegisterRt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return {6'h23, addr[6:2], addr[6:2] ^ 5'h1F, addr[15:0]};
    endfunction

    assign imem_rdata = memWord(imem_addr);

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic pw, input logic iw, input logic ps,
                                 input logic [31:0] tgt, input logic rdy);
        PCWrite      = pw;
        IF_IDWrite   = iw;
        PCSrc        = ps;
        BranchTarget = tgt;
        imem_ready   = rdy;
        tick();
    endtask

    task automatic doReset();
        PCWrite      = 1'b1;
        IF_IDWrite   = 1'b1;
        PCSrc        = 1'b0;
        BranchTarget = 32'd0;
        imem_ready   = 1'b0;
        rst          = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] expWord;

        // Reset state
        PCWrite = 1'b1; IF_IDWrite = 1'b1; PCSrc = 1'b0; BranchTarget = 32'd0; imem_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
        checkOutput("rst_pc", PC, 32'h0);
        checkOutput("rst_valid", {31'd0, IF_ID_Valid}, 32'd0);
        checkOutput("rst_instr", IF_ID_Instr, 32'h0);
        checkOutput("rst_pcplus4", IF_ID_PCPlus4, 32'h0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_req", {31'd0, imem_req}, 32'd1);
        checkOutput("post_rst_addr", imem_addr, 32'h0);

        // Zero-wait memory, no stalls
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
            checkOutput("zw_pcplus4", IF_ID_PCPlus4, 32'(i * 4));
            checkOutput("zw_valid", {31'd0, IF_ID_Valid}, 32'd1);
            checkOutput("zw_instr", IF_ID_Instr, memWord(32'((i - 1) * 4)));
        end
        checkOutput("zw_pc", PC, 32'h10);
        expWord = memWord(32'hC);
        checkOutput("zw_rs", {27'd0, IF_ID_RegisterRs}, {27'd0, expWord[25:21]});
        checkOutput("zw_rt", {27'd0, IF_ID_RegisterRt}, {27'd0, expWord[20:16]});

        // Load-use stall at PC=8, then split stalls
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        checkOutput("lu_pc_before", PC, 32'h8);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("lu_hold_instr", IF_ID_Instr, memWord(32'h4));
        checkOutput("lu_hold_pcplus4", IF_ID_PCPlus4, 32'h8);
        checkOutput("lu_hold_pc", PC, 32'h8);
        checkOutput("lu_buf_req", {31'd0, imem_req}, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        checkOutput("lu_next_instr", IF_ID_Instr, memWord(32'h8));
        checkOutput("lu_next_pcplus4", IF_ID_PCPlus4, 32'hC);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        checkOutput("lu_after_instr", IF_ID_Instr, memWord(32'hC));
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("split1_pc", PC, 32'h10);
        checkOutput("split1_instr", IF_ID_Instr, memWord(32'hC));
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        checkOutput("split2_instr", IF_ID_Instr, memWord(32'hC));
        checkOutput("split2_valid", {31'd0, IF_ID_Valid}, 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        checkOutput("split_release_instr", IF_ID_Instr, memWord(32'h10));
        checkOutput("split_release_pc", PC, 32'h14);

        // Three-cycle memory latency
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        checkOutput("lat_first_instr", IF_ID_Instr, memWord(32'h0));
        checkOutput("lat_first_valid", {31'd0, IF_ID_Valid}, 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        checkOutput("lat_bubble1_valid", {31'd0, IF_ID_Valid}, 32'd0);
        checkOutput("lat_bubble1_instr", IF_ID_Instr, 32'h0);
        checkOutput("lat_addr_stable", imem_addr, 32'h4);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        checkOutput("lat_bubble2_valid", {31'd0, IF_ID_Valid}, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        checkOutput("lat_second_instr", IF_ID_Instr, memWord(32'h4));
        checkOutput("lat_second_pcplus4", IF_ID_PCPlus4, 32'h8);

        // Redirect while the fetch of 0x20 is outstanding
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        checkOutput("br_pc_pre", PC, 32'h20);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h100, 1'b0);
        checkOutput("br_pc", PC, 32'h100);
        checkOutput("br_bubble_valid", {31'd0, IF_ID_Valid}, 32'd0);
        checkOutput("br_bubble_instr", IF_ID_Instr, 32'h0);
        checkOutput("br_drop_addr", imem_addr, 32'h20);
        checkOutput("br_drop_req", {31'd0, imem_req}, 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        checkOutput("br_drop_addr2", imem_addr, 32'h20);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        checkOutput("br_dropped_valid", {31'd0, IF_ID_Valid}, 32'd0);
        checkOutput("br_new_addr", imem_addr, 32'h100);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        checkOutput("br_target_instr", IF_ID_Instr, memWord(32'h100));
        checkOutput("br_target_pcplus4", IF_ID_PCPlus4, 32'h104);

        // Redirect while a stalled word sits in the hold buffer
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("bufbr_stalled_req", {31'd0, imem_req}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
        checkOutput("bufbr_pc", PC, 32'h200);
        checkOutput("bufbr_valid", {31'd0, IF_ID_Valid}, 32'd0);
        checkOutput("bufbr_instr", IF_ID_Instr, 32'h0);
        checkOutput("bufbr_addr", imem_addr, 32'h200);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        checkOutput("bufbr_target_instr", IF_ID_Instr, memWord(32'h200));
        checkOutput("bufbr_target_pcplus4", IF_ID_PCPlus4, 32'h204);

        // PC+4 wraps at the top of the address space
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
        checkOutput("wrap_pc_target", PC, 32'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        checkOutput("wrap_pcplus4", IF_ID_PCPlus4, 32'h0);
        checkOutput("wrap_pc", PC, 32'h0);
        checkOutput("wrap_instr", IF_ID_Instr, memWord(32'hFFFF_FFFC));

        // Reset pulsed mid-fetch at PC=0x40
        doReset();
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        checkOutput("mid_pc_pre", PC, 32'h40);
        rst = 1'b1;
        imem_ready = 1'b1;
        #1;
        checkOutput("mid_rst_pc", PC, 32'h0);
        checkOutput("mid_rst_valid", {31'd0, IF_ID_Valid}, 32'd0);
        checkOutput("mid_rst_req", {31'd0, imem_req}, 32'd0);
        tick();
        checkOutput("mid_rst_pc_hold", PC, 32'h0);
        rst = 1'b0;
        #1;
        checkOutput("mid_restart_addr", imem_addr, 32'h0);
        checkOutput("mid_restart_req", {31'd0, imem_req}, 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        checkOutput("mid_restart_instr", IF_ID_Instr, memWord(32'h0));
        checkOutput("mid_restart_pcplus4", IF_ID_PCPlus4, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
